hs_stream_writer: RTL and testbench
===================================

# hs_stream_writer

Valid/ready stream sink that receives a burst of words and writes them into a byte-addressed memory port. It is the write-side counterpart of the handshake master that reads memory and streams it out: it sits at the consumer end of the slave's `s_valid`/`s_ready` channel and turns each accepted beat into a memory write at an incrementing address. A `start` pulse arms one burst of `len` words from `base_addr`. `done` reports completion once the last write has been taken by memory.

## Interface
- `WIDTH`, default 8: data word width.
- `ADDR_W`, default 8: memory address width; addresses wrap modulo 2^ADDR_W.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that arms a burst; ignored unless in IDLE.
- `base_addr`, in, ADDR_W: first write address, sampled on `start`.
- `len`, in, ADDR_W+1: words in the burst, 0..2^ADDR_W, sampled on `start`.
- `s_valid`, in, 1: upstream word valid.
- `s_data`, in, WIDTH: upstream word.
- `s_ready`, out, 1: writer can accept a word.
- `wr_en`, out, 1: memory write request.
- `wr_addr`, out, ADDR_W: write address.
- `wr_data`, out, WIDTH: write data.
- `wr_ready`, in, 1: memory takes the write this cycle.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle completion pulse.
- `count`, out, ADDR_W+1: words written in the current or last burst.

## Operation
- Accept: `s_valid && s_ready` at a rising edge. Write: `wr_en && wr_ready` at a rising edge.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE + `start` with `len`≠0 → RUN. This latches `base_addr` and `len`, and clears `count` and the accepted-word index.
  - IDLE + `start` with `len`=0 → DONE. No writes are issued.
  - RUN → DRAIN on the accept that brings the accepted total to `len`.
  - DRAIN → DONE on the write that brings `count` to `len`.
  - DONE → IDLE unconditionally after 1 cycle.
- `s_ready` is 0 in IDLE, DRAIN and DONE. No more than `len` words are ever accepted; excess upstream beats stay pending at the source.
- The k-th accepted word (k from 0) is written to `(base_addr + k) mod 2^ADDR_W`. Words are written in order, with no loss and no duplication.
- `count` increments by 1 per write and holds its final value until the next `start`.
- `wr_en`, `wr_addr` and `wr_data` stay stable while `wr_en && !wr_ready`.
- `start` while `busy` or in DONE is ignored.

## Timing
- Reset values: `s_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `count`=0, state IDLE.
- Reset mid-burst:
  - Immediately discards all buffered words.
  - Drops `wr_en` asynchronously.
  - Issues no further writes.
- `s_ready` rises no earlier than the cycle after the `start` edge. A `start` and `s_valid` in the same cycle never cause an accept.
- `done`=1 for exactly the cycle after the final write edge (or the cycle after `start` when `len`=0). `busy` is 0 in that cycle.
- Full throughput: one word per cycle when `s_valid` and `wr_ready` are held high.

## Configuration
- With `HS_WRITER_SKID_EN` defined (a full register slice):
  - Words pass through a 2-entry register slice.
  - `s_ready` and all `wr_*` outputs are driven directly from registers.
  - An accept at edge N produces `wr_en`=1 from the cycle after edge N.
  - With `wr_ready`=0, at most 2 accepted-but-unwritten words are held. `s_ready` drops registered once both entries are full.
- Without `HS_WRITER_SKID_EN` (combinational pass-through):
  - `wr_en` = `s_valid` & RUN.
  - `wr_data` = `s_data`.
  - `s_ready` = `wr_ready` & RUN.
  - Accept and write happen on the same edge (zero latency), and DRAIN lasts 0 cycles: RUN → DONE directly.

## Structure
- Shared package `hs_pkg` holds:
  - the state enum `hs_wr_state_t` (IDLE, RUN, DRAIN, DONE);
  - default `WIDTH` and `ADDR_W` localparams.
- Sub-module `hs_skid_buf`: a 2-entry valid/ready register slice parameterised by payload width. It carries `{addr, data}` and is instantiated only under `HS_WRITER_SKID_EN`.
- The top level holds the FSM, address/index counter, `count`, and `done` generation.

## Test plan
- base=0x10, len=4, data 0x01..0x04 back-to-back, `wr_ready`=1 → mem[0x10..0x13]=01..04; `done` pulses exactly once; `count`=4; `s_ready` low after the 4th accept.
- base=0xFE, len=4, data 0xA0..0xA3 → writes to 0xFE, 0xFF, 0x00, 0x01 in order; no write to 0x02.
- len=3, `s_valid` held high with 6 words 0x11..0x16, `wr_ready` low for 3 cycles mid-burst (skid build):
  - only 0x11..0x13 are written;
  - outstanding words never exceed 2;
  - `wr_*` stays stable while stalled;
  - 0x14 is never accepted.
- `start` with len=0 → `done` for 1 cycle the next cycle; no `wr_en`; `count`=0. A second `start` during `busy` is ignored.
- Reset driven low after 2 of 5 words are accepted → `wr_en`=0 immediately; after release, outputs are at reset values; a new burst base=0x40, len=2 completes correctly.
- Random `s_valid`/`wr_ready` patterns, len=256, base=0x00 → every memory location holds its streamed word exactly once; `count`=256.

Source files
------------

// File: rtl/hs_stream_writer_pkg.sv
// Shared types and default widths for the hs_stream_writer block (package hs_pkg).
package hs_pkg;

  localparam int HS_WIDTH  = 8;
  localparam int HS_ADDR_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } hs_wr_state_t;

endpackage

// File: rtl/hs_stream_writer_if.sv
// Stream-in and memory-write channel bundle for hs_stream_writer.
// The slave modport is the writer's view; master is the environment driving it.
interface hs_stream_writer_if
  import hs_pkg::*;
#(
  parameter int WIDTH  = HS_WIDTH,
  parameter int ADDR_W = HS_ADDR_W
) ();

  logic              s_valid;
  logic [WIDTH-1:0]  s_data;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_ready;

  modport master (
    output s_valid, s_data, wr_ready,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data, wr_ready,
    output s_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/hs_stream_writer_skid_buf.sv
// hs_skid_buf: 2-entry valid/ready register slice; in_ready and all out_* come straight from flops.
module hs_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         sk_valid;
  logic [W-1:0] sk_data;
  logic         in_fire;
  logic         out_free;

  // The second entry only fills when the output stage is stalled, so an empty
  // skid entry means there is always room for one more word.
  assign in_ready = !sk_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
    end else if (out_free) begin
      if (sk_valid) begin
        out_valid <= 1'b1;
        out_data  <= sk_data;
        sk_valid  <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      sk_valid <= 1'b1;
      sk_data  <= in_data;
    end
  end

endmodule

// File: rtl/hs_stream_writer.sv
// Stream sink that writes a burst of accepted words to incrementing memory addresses.
// Define HS_WRITER_SKID_EN to insert a registered 2-entry slice between stream and memory port.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; s_ready low
// S_RUN   | accepting words until len have been taken
// S_DRAIN | all words accepted, waiting for buffered writes (slice only)
// S_DONE  | one-cycle completion, done high
module hs_stream_writer
  import hs_pkg::*;
#(
  parameter int WIDTH  = HS_WIDTH,
  parameter int ADDR_W = HS_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  hs_stream_writer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  hs_wr_state_t      state, state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W-1:0] addr;
  logic              run;
  logic              start_ok;
  logic              accept;
  logic              write;
  logic              last_accept;
  logic              last_write;

  assign run         = (state == S_RUN);
  assign start_ok    = start && (state == S_IDLE);
  assign accept      = bus.s_valid && bus.s_ready;
  assign write       = bus.wr_en && bus.wr_ready;
  assign last_accept = accept && ((idx + LEN_ONE) == len_q);
  assign last_write  = write && ((count + LEN_ONE) == len_q);

`ifdef HS_WRITER_SKID_EN
  logic                     sb_in_ready;
  logic [ADDR_W+WIDTH-1:0] sb_out_data;

  // Address travels with its word so the slice output is a complete write.
  hs_skid_buf #(.W(ADDR_W + WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.s_valid && run),
    .in_ready  (sb_in_ready),
    .in_data   ({addr, bus.s_data}),
    .out_valid (bus.wr_en),
    .out_ready (bus.wr_ready),
    .out_data  (sb_out_data)
  );

  assign bus.wr_addr = sb_out_data[ADDR_W+WIDTH-1:WIDTH];
  assign bus.wr_data = sb_out_data[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (last_accept) begin
`ifdef HS_WRITER_SKID_EN
          state_nxt = S_DRAIN;
`else
          state_nxt = S_DONE;
`endif
        end
      end
      S_DRAIN: if (last_write) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = run || (state == S_DRAIN);
    done = (state == S_DONE);
`ifdef HS_WRITER_SKID_EN
    bus.s_ready = sb_in_ready && run;
`else
    bus.s_ready = bus.wr_ready && run;
    bus.wr_en   = bus.s_valid && run;
    bus.wr_addr = addr;
    // Gated so the data bus reads zero whenever no burst is running.
    bus.wr_data = run ? bus.s_data : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
      idx   <= '0;
      addr  <= '0;
      count <= '0;
    end else if (start_ok) begin
      len_q <= len;
      idx   <= '0;
      addr  <= base_addr;
      count <= '0;
    end else begin
      if (accept) begin
        idx  <= idx + LEN_ONE;
        addr <= addr + ADDR_ONE;
      end
      if (write) count <= count + LEN_ONE;
    end
  end

endmodule

// File: tb/tb_hs_stream_writer.sv
// Randomised self-checking bench for hs_stream_writer; memory-side effects compared with a burst model.
module tb_hs_stream_writer;
  import hs_pkg::*;

  localparam int WIDTH  = HS_WIDTH;
  localparam int ADDR_W = HS_ADDR_W;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef HS_WRITER_SKID_EN
  localparam int MAX_OUT = 2;
`else
  localparam int MAX_OUT = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;

  hs_stream_writer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  hs_stream_writer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] src_q[$];
  bit held = 0;
  int cyc = 0;
  int vpct = 100, rpct = 100, stall_at = 0, stall_n = 0;

  int acc_n, wr_n, done_n, done_busy, stab_err, max_out, wfirst, wlast;
  logic [ADDR_W-1:0] wlog_a[$];
  logic [WIDTH-1:0]  wlog_d[$];
  int                hits[DEPTH];
  logic [WIDTH-1:0]  mem[DEPTH];
  bit                stall_prev = 0;
  logic [ADDR_W-1:0] pa;
  logic [WIDTH-1:0]  pd;

  // Observes what happens at the coming rising edge; inputs only change just after edges.
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev && (bus.wr_en !== 1'b1 || bus.wr_addr !== pa || bus.wr_data !== pd)) stab_err++;
      stall_prev = bus.wr_en && !bus.wr_ready;
      pa = bus.wr_addr;
      pd = bus.wr_data;
      if (bus.s_valid && bus.s_ready) acc_n++;
      if (bus.wr_en && bus.wr_ready) begin
        wlog_a.push_back(bus.wr_addr);
        wlog_d.push_back(bus.wr_data);
        mem[bus.wr_addr] = bus.wr_data;
        hits[bus.wr_addr]++;
        if (wr_n == 0) wfirst = cyc;
        wlast = cyc;
        wr_n++;
      end
      if (done) begin
        done_n++;
        if (busy) done_busy++;
      end
      if (acc_n - wr_n > max_out) max_out = acc_n - wr_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    acc_n = 0; wr_n = 0; done_n = 0; done_busy = 0; stab_err = 0; max_out = 0;
    wfirst = 0; wlast = 0;
    wlog_a.delete();
    wlog_d.delete();
    for (int a = 0; a < DEPTH; a++) begin
      hits[a] = 0;
      mem[a]  = '0;
    end
  endtask

  task automatic load_src(input int n, input int first);
    src_q.delete();
    held = 0;
    for (int i = 0; i < n; i++)
      src_q.push_back((first < 0) ? WIDTH'($urandom) : WIDTH'(first + i));
  endtask

  task automatic step();
    bit acc;
    if (!held) begin
      bus.s_valid = (src_q.size() > 0) && ($urandom_range(99) < vpct);
      if (src_q.size() > 0) bus.s_data = src_q[0];
    end
    bus.wr_ready = (cyc >= stall_at && cyc < stall_at + stall_n) ? 1'b0 : ($urandom_range(99) < rpct);
    @(negedge clk);
    acc = bus.s_valid && bus.s_ready;
    @(posedge clk);
    #1;
    if (acc) void'(src_q.pop_front());
    held = bus.s_valid && !acc;
    cyc++;
  endtask

  task automatic run_burst(input logic [ADDR_W-1:0] b, input int l, input int restart_at);
    int n = 0;
    clear_mon();
    cyc = 0;
    base_addr = b;
    len = (ADDR_W+1)'(l);
    start = 1'b1;
    step();
    start = 1'b0;
    base_addr = b ^ 8'h55;
    len = 9'd7;
    while (done_n == 0 && n < 4000) begin
      start = (n == restart_at);
      step();
      start = 1'b0;
      n++;
    end
    tests++;
    if (done_n == 0) begin
      fails++;
      $display("FAIL burst_timeout: done not seen after %0d cycles, required within 4000", n);
    end
    repeat (3) step();
  endtask

  // Model: the k-th word handed to the source lands at (base + k) mod 2^ADDR_W, once, in order.
  function automatic bit writes_ok(input logic [ADDR_W-1:0] b, input int l, input logic [WIDTH-1:0] exp[$]);
    logic [ADDR_W-1:0] ea;
    if (wlog_a.size() != l) return 0;
    for (int k = 0; k < l; k++) begin
      ea = ADDR_W'((int'(b) + k) % DEPTH);
      if (wlog_a[k] !== ea || wlog_d[k] !== exp[k]) return 0;
    end
    return 1;
  endfunction

  task automatic test_reset();
    bus.s_valid = 1'b0; bus.s_data = '0; bus.wr_ready = 1'b0;
    #1;
    tests++;
    if ({bus.s_ready, bus.wr_en, busy, done} !== 4'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0 || count !== '0) begin
      fails++;
      $display("FAIL reset_in: s_ready=%b wr_en=%b busy=%b done=%b addr=%h data=%h count=%0d, required all zero",
               bus.s_ready, bus.wr_en, busy, done, bus.wr_addr, bus.wr_data, count);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({bus.s_ready, bus.wr_en, busy, done} !== 4'b0 || count !== '0) begin
      fails++;
      $display("FAIL reset_out: s_ready=%b wr_en=%b busy=%b done=%b count=%0d, required all zero",
               bus.s_ready, bus.wr_en, busy, done, count);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] exp[$];
    load_src(4, 1);
    exp = src_q;
    vpct = 100; rpct = 100; stall_n = 0;
    run_burst(8'h10, 4, -1);
    tests++;
    if (!writes_ok(8'h10, 4, exp) || mem[8'h13] !== 8'h04) begin
      fails++;
      $display("FAIL basic_writes: %0d writes seen, required 01..04 at 10..13", wr_n);
    end
    tests++;
    if (count !== 9'd4 || acc_n !== 4) begin
      fails++;
      $display("FAIL basic_count: count=%0d accepts=%0d, required 4 and 4", count, acc_n);
    end
    tests++;
    if (done_n !== 1 || done_busy !== 0) begin
      fails++;
      $display("FAIL basic_done: pulses=%0d busy_with_done=%0d, required 1 and 0", done_n, done_busy);
    end
    tests++;
    if (wlast - wfirst !== 3 || bus.s_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_throughput: write span=%0d s_ready=%b, required 3 and 0", wlast - wfirst, bus.s_ready);
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] exp[$];
    load_src(4, 8'hA0);
    exp = src_q;
    vpct = 100; rpct = 100; stall_n = 0;
    run_burst(8'hFE, 4, -1);
    tests++;
    if (!writes_ok(8'hFE, 4, exp) || hits[2] !== 0) begin
      fails++;
      $display("FAIL wrap_writes: %0d writes, hits[02]=%0d, required FE,FF,00,01 and 0", wr_n, hits[2]);
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] exp[$];
    load_src(6, 8'h11);
    exp = src_q;
    vpct = 100; rpct = 100; stall_at = 2; stall_n = 3;
    run_burst(8'h20, 3, -1);
    stall_n = 0;
    tests++;
    if (!writes_ok(8'h20, 3, exp) || count !== 9'd3) begin
      fails++;
      $display("FAIL stall_writes: %0d writes count=%0d, required 11..13 and 3", wr_n, count);
    end
    tests++;
    if (src_q.size() !== 3 || src_q[0] !== 8'h14) begin
      fails++;
      $display("FAIL stall_excess: pending=%0d head=%h, required 3 and 14", src_q.size(), src_q[0]);
    end
    tests++;
    if (max_out > MAX_OUT || stab_err !== 0) begin
      fails++;
      $display("FAIL stall_hold: outstanding=%0d unstable=%0d, required <=%0d and 0", max_out, stab_err, MAX_OUT);
    end
  endtask

  task automatic test_len0_restart();
    logic [WIDTH-1:0] exp[$];
    load_src(2, 8'h77);
    vpct = 100; rpct = 100; stall_n = 0;
    clear_mon();
    cyc = 0;
    base_addr = 8'h30; len = '0; start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL len0_done: done=%b busy=%b, required 1 and 0", done, busy);
    end
    step();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL len0_pulse: done=%b one cycle later, required 0", done);
    end
    repeat (2) step();
    tests++;
    if (wr_n !== 0 || acc_n !== 0 || count !== '0 || done_n !== 1) begin
      fails++;
      $display("FAIL len0_quiet: writes=%0d accepts=%0d count=%0d pulses=%0d, required 0 0 0 1", wr_n, acc_n, count, done_n);
    end
    load_src(5, -1);
    exp = src_q;
    vpct = 70; rpct = 70;
    run_burst(8'h50, 3, 1);
    tests++;
    if (!writes_ok(8'h50, 3, exp) || count !== 9'd3 || done_n !== 1) begin
      fails++;
      $display("FAIL restart_ignored: writes=%0d count=%0d pulses=%0d, required 3 3 1", wr_n, count, done_n);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] exp[$];
    int n = 0;
    int wr_snap;
    load_src(5, 8'hC1);
    vpct = 100; rpct = 100; stall_n = 0;
    clear_mon();
    cyc = 0;
    base_addr = 8'h60; len = 9'd5; start = 1'b1;
    step();
    start = 1'b0;
    while (acc_n < 2 && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (acc_n < 2) begin
      fails++;
      $display("FAIL rstmid_accepts: %0d accepts, required 2", acc_n);
    end
    wr_snap = wr_n;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.wr_en !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_wr_en: wr_en=%b during reset, required 0", bus.wr_en);
    end
    bus.s_valid = 1'b0;
    held = 0;
    src_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({bus.s_ready, bus.wr_en, busy, done} !== 4'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0 || count !== '0 || wr_n !== wr_snap) begin
      fails++;
      $display("FAIL rstmid_values: s_ready=%b wr_en=%b busy=%b done=%b addr=%h data=%h count=%0d extra_writes=%0d, required zeros",
               bus.s_ready, bus.wr_en, busy, done, bus.wr_addr, bus.wr_data, count, wr_n - wr_snap);
    end
    @(posedge clk);
    #1;
    load_src(2, -1);
    exp = src_q;
    run_burst(8'h40, 2, -1);
    tests++;
    if (!writes_ok(8'h40, 2, exp) || count !== 9'd2) begin
      fails++;
      $display("FAIL rstmid_after: writes=%0d count=%0d, required 2 at 40..41 and 2", wr_n, count);
    end
  endtask

  task automatic test_random_bursts();
    logic [WIDTH-1:0] exp[$];
    logic [ADDR_W-1:0] b;
    int l;
    for (int it = 0; it < 3; it++) begin
      b = ADDR_W'($urandom);
      l = $urandom_range(1, 40);
      load_src(l + 3, -1);
      exp = src_q;
      vpct = 50; rpct = 50; stall_n = 0;
      run_burst(b, l, -1);
      tests++;
      if (!writes_ok(b, l, exp) || count !== (ADDR_W+1)'(l) || stab_err !== 0) begin
        fails++;
        $display("FAIL rand_burst%0d: base=%h writes=%0d count=%0d unstable=%0d, required len %0d", it, b, wr_n, count, stab_err, l);
      end
    end
  endtask

  task automatic test_full_random();
    logic [WIDTH-1:0] exp[$];
    int bad = 0;
    load_src(DEPTH + 4, -1);
    exp = src_q;
    vpct = 70; rpct = 60; stall_n = 0;
    run_burst('0, DEPTH, -1);
    for (int a = 0; a < DEPTH; a++)
      if (hits[a] != 1 || mem[a] !== exp[a]) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL full_mem: %0d locations wrong or not written once, required 0", bad);
    end
    tests++;
    if (count !== 9'd256 || acc_n !== DEPTH || max_out > MAX_OUT) begin
      fails++;
      $display("FAIL full_count: count=%0d accepts=%0d outstanding=%0d, required 256 256 <=%0d", count, acc_n, max_out, MAX_OUT);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_len0_restart();
    test_reset_mid();
    test_random_bursts();
    test_full_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
